// File: rtl/imem_loader.sv
// Byte-stream boot loader: writes a framed, XOR-checked program image into the
// instruction memory, holding the CPU in reset until the load succeeds.
`timescale 1ns/1ps
module imem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
    S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_e;

  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        xfer;
  logic [15:0] n_w;
  logic [15:0] cnt_inc;

  assign xfer    = s_valid & ready_q;
  assign n_w     = {len_hi_q, s_data};
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    hi_d     = hi_q;
    csum_d   = csum_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_LEN_HI: begin
        csum_d = 8'h00;
        if (xfer) begin
          len_hi_d = s_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = n_w;
          if (n_w == 16'd0)              state_d = S_CSUM;
          else if ({1'b0, n_w} > MAXW)   state_d = S_ERR;
          else                           state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          hi_d    = s_data;
          csum_d  = csum_q ^ s_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          csum_d  = csum_q ^ s_data;
          wdata_d = {hi_q, s_data};
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_inc;
        addr_d  = addr_q + 16'd2;
        state_d = (cnt_inc == len_q) ? S_CSUM : S_DATA_HI;
      end
      S_CSUM: begin
        if (xfer) state_d = (s_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = state_q;
    endcase
    // Outputs are registered from the next state so they line up with it.
    we_d      = (state_d == S_WRITE);
    ready_d   = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                (state_d == S_DATA_HI) || (state_d == S_DATA_LO) ||
                (state_d == S_CSUM);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
    cpu_rst_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_LEN_HI;
      len_hi_q  <= 8'h00;
      len_q     <= 16'h0000;
      hi_q      <= 8'h00;
      csum_q    <= 8'h00;
      wdata_q   <= 16'h0000;
      addr_q    <= BASE_ADDR;
      cnt_q     <= 16'h0000;
      we_q      <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      len_q     <= len_d;
      hi_q      <= hi_d;
      csum_q    <= csum_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign s_ready      = ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_reset    = cpu_rst_q;
  assign done         = done_q;
  assign error        = err_q;
  assign words_loaded = cnt_q;

endmodule
